// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU sprite pipeline.
//   eval_state_t - sprite evaluation FSM states
//   SPRITE_H8/H16 - sprite heights in rows (9-bit to compare against a
//                   lineCount difference without casts)
//   SEC_OAM_FILL  - value written to every secondary OAM byte during clear
package ppu_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    EVAL_Y,
    COPY,
    OVF_SEARCH,
    DONE
  } eval_state_t;

  localparam logic [8:0] SPRITE_H8    = 9'd8;
  localparam logic [8:0] SPRITE_H16   = 9'd16;
  localparam logic [7:0] SEC_OAM_FILL = 8'hFF;

endpackage

// File: rtl/sprite_range_check.sv
// sprite_range_check: combinational test of whether a sprite whose top row
// is y_i covers scanline line_i.
//   line_i     - current scanline (9 bit)
//   y_i        - sprite Y byte from OAM
//   size16_i   - 1 = 16-row sprites, 0 = 8-row sprites
//   in_range_o - line_i - y_i is non-negative and below the sprite height
module sprite_range_check
  import ppu_pkg::*;
(
  input  logic [8:0] line_i,
  input  logic [7:0] y_i,
  input  logic       size16_i,
  output logic       in_range_o
);

  // One extra bit so a Y below the line shows up as a borrow in diff[9].
  logic [9:0] diff;

  assign diff       = {1'b0, line_i} - {2'b00, y_i};
  assign in_range_o = !diff[9] && (diff[8:0] < (size16_i ? SPRITE_H16 : SPRITE_H8));

endmodule

// File: rtl/sprite_evaluator.sv
// sprite_evaluator: per-scanline sprite evaluation. Clears secondary OAM,
// scans primary OAM for sprites covering lineCount, copies up to SEC_SLOTS
// of them, then runs the (buggy) overflow search.
//   clock/reset_n    - PPU clock, async active-low reset
//   clock_EN         - dot enable
//   spriteEval_EN    - evaluation window (dots 1..256)
//   spriteEvalReset  - restart strobe at dot 340
//   lineCount        - current scanline; spriteSize16 - sprite height select
//   oamAddr/oamData  - primary OAM read port (data one enabled cycle later)
//   secAddr/secWrData/secWe - registered secondary OAM write port
//   overflowSet      - one-cycle overflow pulse
//   sprite0Next/spriteCount - results of the last completed evaluation
module sprite_evaluator
  import ppu_pkg::*;
#(
  parameter int OAM_ENTRIES = 64,
  parameter int SEC_SLOTS   = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_EN,
  input  logic       spriteEval_EN,
  input  logic       spriteEvalReset,
  input  logic [8:0] lineCount,
  input  logic       spriteSize16,
  output logic [7:0] oamAddr,
  input  logic [7:0] oamData,
  output logic [4:0] secAddr,
  output logic [7:0] secWrData,
  output logic       secWe,
  output logic       overflowSet,
  output logic       sprite0Next,
  output logic [3:0] spriteCount
);

  localparam logic [5:0] N_LAST = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] FULL   = 4'(SEC_SLOTS);

  eval_state_t state_q, state_d;
  logic [7:0]  d_q, d_d;
  logic [5:0]  n_q, n_d;
  logic [1:0]  m_q, m_d;
  logic [3:0]  found_q, found_d;
  logic        s0_q, s0_d;          // entry 0 copied on this line
  logic        ovf_done_q, ovf_done_d;
  logic [7:0]  hold_q, hold_d;      // last address read before DONE
  logic [4:0]  sec_addr_q, sec_addr_d;
  logic [7:0]  sec_data_q, sec_data_d;
  logic        sec_we_q, sec_we_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        s0n_q, s0n_d;

  logic en, act, n_last, in_range;

  assign en     = clock_EN & spriteEval_EN;
  assign act    = d_q[0];
  assign n_last = (n_q == N_LAST);

  sprite_range_check u_range (
    .line_i    (lineCount),
    .y_i       (oamData),
    .size16_i  (spriteSize16),
    .in_range_o(in_range)
  );

  // m is 0 outside COPY/OVF_SEARCH, so {n,m} is also the Y address in EVAL_Y.
  assign oamAddr     = (state_q == DONE) ? hold_q : {n_q, m_q};
  assign secAddr     = sec_addr_q;
  assign secWrData   = sec_data_q;
  assign secWe       = sec_we_q;
  assign overflowSet = ovf_q;
  assign sprite0Next = s0n_q;
  assign spriteCount = cnt_q;

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    n_d        = n_q;
    m_d        = m_q;
    found_d    = found_q;
    s0_d       = s0_q;
    ovf_done_d = ovf_done_q;
    hold_d     = hold_q;
    sec_addr_d = sec_addr_q;
    sec_data_d = sec_data_q;
    sec_we_d   = 1'b0;
    ovf_d      = 1'b0;
    cnt_d      = cnt_q;
    s0n_d      = s0n_q;

    if (clock_EN && spriteEvalReset) begin
      state_d    = CLEAR;
      d_d        = 8'd0;
      n_d        = 6'd0;
      m_d        = 2'd0;
      found_d    = 4'd0;
      s0_d       = 1'b0;
      ovf_done_d = 1'b0;
    end else if (en) begin
      d_d = d_q + 8'd1;
      if (state_q != DONE) hold_d = {n_q, m_q};
      if (act) begin
        if (d_q == 8'd255) begin
          cnt_d = found_q;
          s0n_d = s0_q;
        end
        case (state_q)
          CLEAR: begin
            sec_we_d   = 1'b1;
            sec_addr_d = d_q[5:1];
            sec_data_d = SEC_OAM_FILL;
            if (d_q == 8'd63) state_d = EVAL_Y;
          end
          EVAL_Y: begin
            // Y is copied even for misses; the next hit overwrites the slot.
            if (found_q < FULL) begin
              sec_we_d   = 1'b1;
              sec_addr_d = {found_q[2:0], 2'b00};
              sec_data_d = oamData;
            end
            if (in_range) begin
              state_d = COPY;
              m_d     = 2'd1;
              if (n_q == 6'd0) s0_d = 1'b1;
            end else begin
              n_d = n_q + 6'd1;
              if (n_last) state_d = DONE;
            end
          end
          COPY: begin
            sec_we_d   = 1'b1;
            sec_addr_d = {found_q[2:0], m_q};
            sec_data_d = oamData;
            if (m_q == 2'd3) begin
              found_d = found_q + 4'd1;
              n_d     = n_q + 6'd1;
              m_d     = 2'd0;
              if (n_last)                       state_d = DONE;
              else if (found_q + 4'd1 == FULL)  state_d = OVF_SEARCH;
              else                              state_d = EVAL_Y;
            end else begin
              m_d = m_q + 2'd1;
            end
          end
          OVF_SEARCH: begin
            if (in_range) begin
              ovf_d      = !ovf_done_q;
              ovf_done_d = 1'b1;
              state_d    = DONE;
            end else begin
              // m also steps on a miss: the diagonal walk of the real chip.
              n_d = n_q + 6'd1;
              m_d = m_q + 2'd1;
              if (n_last) state_d = DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      d_q        <= 8'd0;
      n_q        <= 6'd0;
      m_q        <= 2'd0;
      found_q    <= 4'd0;
      s0_q       <= 1'b0;
      ovf_done_q <= 1'b0;
      hold_q     <= 8'd0;
      sec_addr_q <= 5'd0;
      sec_data_q <= 8'd0;
      sec_we_q   <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= 4'd0;
      s0n_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      n_q        <= n_d;
      m_q        <= m_d;
      found_q    <= found_d;
      s0_q       <= s0_d;
      ovf_done_q <= ovf_done_d;
      hold_q     <= hold_d;
      sec_addr_q <= sec_addr_d;
      sec_data_q <= sec_data_d;
      sec_we_q   <= sec_we_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      s0n_q      <= s0n_d;
    end
  end

endmodule

// File: tb/tb_sprite_evaluator.sv
// Bench for sprite_evaluator: table of per-line scenarios plus a hand-written
// restart / enable-drop sequence. Expected secondary OAM writes come from a
// reference walk of primary OAM and are queued, then popped as secWe fires.
module tb_sprite_evaluator;

  logic       clock, reset_n, clock_EN, spriteEval_EN, spriteEvalReset;
  logic [8:0] lineCount;
  logic       spriteSize16;
  logic [7:0] oamAddr, oamData;
  logic [4:0] secAddr;
  logic [7:0] secWrData;
  logic       secWe, overflowSet, sprite0Next;
  logic [3:0] spriteCount;

  sprite_evaluator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .clock_EN       (clock_EN),
    .spriteEval_EN  (spriteEval_EN),
    .spriteEvalReset(spriteEvalReset),
    .lineCount      (lineCount),
    .spriteSize16   (spriteSize16),
    .oamAddr        (oamAddr),
    .oamData        (oamData),
    .secAddr        (secAddr),
    .secWrData      (secWrData),
    .secWe          (secWe),
    .overflowSet    (overflowSet),
    .sprite0Next    (sprite0Next),
    .spriteCount    (spriteCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] oam [256];
  always @(posedge clock) if (clock_EN) oamData <= oam[oamAddr];

  typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t sbq[$];
  wr_t e;

  typedef struct {
    int         setup;
    logic [8:0] line;
    logic       s16;
    logic [3:0] cnt;
    logic       s0;
    int         novf;
    logic [7:0] oaddr;
  } vec_t;
  vec_t tbl[7];

  int         checks = 0, failures = 0;
  bit         mon_on = 0;
  int         ovf_cnt = 0;
  logic [7:0] ovf_addr = 8'd0;
  logic [7:0] saved;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, return 1 time unit past the rising edge.
  task automatic tick();
    @(negedge clock);
    if (mon_on) begin
      if (secWe) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL sec_write_extra: got addr=%0d data=%h, expected no write", secAddr, secWrData);
        end else begin
          e = sbq.pop_front();
          if (secAddr !== e.a || secWrData !== e.d) begin
            failures++;
            $display("FAIL sec_write: got addr=%0d data=%h expected addr=%0d data=%h",
                     secAddr, secWrData, e.a, e.d);
          end
        end
      end
      if (overflowSet) begin
        ovf_cnt++;
        ovf_addr = oamAddr;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic dots(input int k);
    spriteEval_EN = 1'b1;
    repeat (k) tick();
    spriteEval_EN = 1'b0;
  endtask

  task automatic fill_oam(input int id);
    for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    case (id)
      1: begin oam[0] = 8'd5; oam[1] = 8'hA1; oam[2] = 8'hA2; oam[3] = 8'hA3; end
      2: begin oam[12] = 8'd0; oam[13] = 8'h11; oam[14] = 8'h22; oam[15] = 8'h33; end
      4, 5, 6: begin
        for (int s = 0; s < 9; s++) begin
          oam[s*4]   = 8'd20;
          oam[s*4+1] = 8'(s);
          oam[s*4+2] = 8'(8'h40 + s);
          oam[s*4+3] = 8'(8'h80 + s);
        end
        if (id != 4) begin
          oam[32] = 8'd0; oam[33] = 8'hFF; oam[34] = 8'hFF; oam[35] = 8'hFF;
        end
        if (id == 5) oam[37] = 8'd20;
      end
      default: ;
    endcase
  endtask

  function automatic bit hit(input int line, input int y, input int h);
    return (line >= y) && (line - y < h);
  endfunction

  task automatic push_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 5'(a);
    w.d = d;
    sbq.push_back(w);
  endtask

  // Reference write stream: 32 clears, then each scanned entry's Y into the
  // next free slot, plus bytes 1..3 for hits, until 8 found or OAM exhausted.
  task automatic model(input int line, input bit s16);
    int found, n, h;
    sbq.delete();
    h = s16 ? 16 : 8;
    for (int a = 0; a < 32; a++) push_wr(a, 8'hFF);
    found = 0;
    n = 0;
    while (n < 64 && found < 8) begin
      push_wr(found*4, oam[n*4]);
      if (hit(line, int'(oam[n*4]), h)) begin
        for (int k = 1; k < 4; k++) push_wr(found*4 + k, oam[n*4 + k]);
        found++;
      end
      n++;
    end
  endtask

  task automatic start_line(input int setup, input logic [8:0] line, input logic s16);
    fill_oam(setup);
    lineCount       = line;
    spriteSize16    = s16;
    spriteEvalReset = 1'b1;
    tick();
    spriteEvalReset = 1'b0;
    model(int'(line), s16);
    ovf_cnt = 0;
    mon_on  = 1'b1;
  endtask

  task automatic finish_line(input string tag, input vec_t v);
    repeat (4) tick();
    chk({tag, " spriteCount"}, spriteCount, v.cnt);
    chk({tag, " sprite0Next"}, sprite0Next, v.s0);
    chk({tag, " overflow_pulses"}, ovf_cnt, v.novf);
    if (v.novf != 0) chk({tag, " overflow_addr"}, ovf_addr, v.oaddr);
    chk({tag, " writes_missing"}, sbq.size(), 0);
    mon_on = 1'b0;
    sbq.delete();
    repeat (60) tick();
    chk({tag, " spriteCount_hold"}, spriteCount, v.cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 9'd0,  1'b0, 4'd0, 1'b0, 0, 8'd0};
    tbl[1] = '{1, 9'd10, 1'b0, 4'd1, 1'b1, 0, 8'd0};
    tbl[2] = '{2, 9'd10, 1'b0, 4'd0, 1'b0, 0, 8'd0};
    tbl[3] = '{2, 9'd10, 1'b1, 4'd1, 1'b0, 0, 8'd0};
    tbl[4] = '{4, 9'd20, 1'b0, 4'd8, 1'b1, 1, 8'd32};
    tbl[5] = '{5, 9'd20, 1'b0, 4'd8, 1'b1, 1, 8'd37};
    tbl[6] = '{6, 9'd20, 1'b0, 4'd8, 1'b1, 0, 8'd0};

    fill_oam(0);
    reset_n = 1'b0; clock_EN = 1'b0; spriteEval_EN = 1'b0; spriteEvalReset = 1'b0;
    lineCount = 9'd0; spriteSize16 = 1'b0;
    repeat (3) tick();
    chk("rst oamAddr", oamAddr, 8'd0);
    chk("rst secAddr", secAddr, 5'd0);
    chk("rst secWrData", secWrData, 8'd0);
    chk("rst secWe", secWe, 1'b0);
    chk("rst overflowSet", overflowSet, 1'b0);
    chk("rst sprite0Next", sprite0Next, 1'b0);
    chk("rst spriteCount", spriteCount, 4'd0);
    reset_n  = 1'b1;
    clock_EN = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      start_line(tbl[i].setup, tbl[i].line, tbl[i].s16);
      dots(256);
      finish_line($sformatf("vec%0d", i), tbl[i]);
    end

    // Restart mid-COPY: entry 4, byte 2 is being read at dot 100.
    start_line(4, 9'd20, 1'b0);
    mon_on = 1'b0;
    dots(100);
    chk("midline oamAddr", oamAddr, 8'd18);
    spriteEval_EN   = 1'b1;
    spriteEvalReset = 1'b1;
    tick();
    spriteEvalReset = 1'b0;
    spriteEval_EN   = 1'b0;
    chk("restart oamAddr", oamAddr, 8'd0);
    model(20, 1'b0);
    ovf_cnt = 0;
    mon_on  = 1'b1;

    // Drop the window for 10 dots while sprite 0 byte 3 is being read.
    dots(70);
    saved = oamAddr;
    chk("freeze oamAddr_before", saved, 8'd3);
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("freeze secWe", secWe, 1'b0);
      chk("freeze oamAddr", oamAddr, saved);
    end
    dots(186);
    finish_line("restart", tbl[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_evaluator.md
Name: sprite_evaluator

Overview:
- Per-scanline sprite evaluation stage, directly downstream of the render timing controller.
- Driven by its spriteEval_EN / spriteEvalReset strobes and lineCount.
- Each line: clears secondary OAM, scans the 64 primary-OAM entries for sprites in range, and copies up to 8 entries into secondary OAM for the sprite fetch stage.
- Produces the sprite-overflow set pulse (including the hardware diagonal-scan bug) and a sprite-0-present flag.

Parameters:
- OAM_ENTRIES, 64, number of primary OAM sprites.
- SEC_SLOTS, 8, secondary OAM sprite capacity.

Ports:
- clock  in  1  PPU clock (same domain as render controller).
- reset_n  in  1  asynchronous active-low reset.
- clock_EN  in  1  dot enable; all state advances only when high.
- spriteEval_EN  in  1  evaluation window strobe (dots 1..256, visible lines, rendering on).
- spriteEvalReset  in  1  one-dot strobe at dot 340; restarts evaluation.
- lineCount  in  9  current scanline.
- spriteSize16  in  1  PPUCTRL sprite height select (0 = 8 rows, 1 = 16 rows).
- oamAddr  out  8  primary OAM read address.
- oamData  in  8  primary OAM read data; valid one enabled cycle after oamAddr.
- secAddr  out  5  secondary OAM write address.
- secWrData  out  8  secondary OAM write data.
- secWe  out  1  secondary OAM write strobe.
- overflowSet  out  1  one-cycle pulse when overflow is detected.
- sprite0Next  out  1  entry 0 was copied during the last completed evaluation.
- spriteCount  out  4  sprites found during the last completed evaluation (0..8).

Behaviour:
- Reset values: all outputs 0; state CLEAR; dot counter 0; n=0, m=0, found=0.
- The dot counter d (8 bit) increments on clock_EN && spriteEval_EN.
- spriteEvalReset (with clock_EN) forces d=0, n=0, m=0, found=0, state CLEAR, and a latched overflow-done flag to 0. It overrides any simultaneous spriteEval_EN.
- spriteEval_EN low mid-line: all state holds, secWe=0.
- Phase: d[0]=0 is the read phase (drive oamAddr). d[0]=1 is the act phase (consume oamData, optionally write).
- CLEAR (d 0..63): each act phase writes secWrData=8'hFF to secAddr=d[5:1]. At d=63 go to EVAL_Y.
- EVAL_Y: read oamAddr = {n,2'b00}. In act phase: diff = lineCount - {1'b0,oamData}, computed 9-bit. inRange = (diff < (spriteSize16 ? 16 : 8)) with no borrow.
  - Copy Y to secAddr={found[2:0],2'b00} unconditionally while found<8.
  - If inRange: go to COPY with m=1; if n==0, set sprite0 pending.
  - Else: n++.
- COPY: reads {n,m} for m=1..3 and writes each to {found,m}. After m=3: found++, n++, m=0.
  - If found becomes 8, go to OVF_SEARCH; otherwise go to EVAL_Y.
- OVF_SEARCH: read {n,m}, no writes, treat the data as Y.
  - inRange: pulse overflowSet; enter DONE.
  - Not inRange: n++ and m++ with 2-bit wrap and no carry into n (the hardware bug).
- n wrap: n incrementing past 63 in any state enters DONE.
- DONE: no reads or writes; oamAddr holds.
- At d=255 act phase, regardless of state: spriteCount <= found and sprite0Next <= sprite0 pending. These registers are stable through dots 257..320.
- overflowSet fires at most once per line.
- secWe is only high in act phases. secWe and secWrData are registered, giving 1 clock latency from the act phase.

Decomposition:
- Shared package ppu_pkg:
  - eval_state_t enum {CLEAR, EVAL_Y, COPY, OVF_SEARCH, DONE}.
  - constants SPRITE_H8=8, SPRITE_H16=16, SEC_OAM_FILL=8'hFF.
- One sub-module sprite_range_check: combinational lineCount/Y/height → inRange. It is shared by EVAL_Y and OVF_SEARCH.

Test Plan:
- Reset, then 256 enabled dots with every Y=8'hFF → 32 writes of FF to secAddr 0..31; spriteCount=0; sprite0Next=0; no overflowSet.
- lineCount=10, entry0 Y=5, 8x8 mode → secondary OAM slot0 = entry0's 4 bytes; spriteCount=1; sprite0Next=1.
- lineCount=10, entry3 Y=0, spriteSize16 = 0 then 1 → excluded in 8-row mode, included in 16-row mode.
- lineCount=20, entries 0..8 all Y=20 → 8 sprites copied, spriteCount=8, overflowSet pulses once during the scan of entry 8.
- lineCount=20, 8 hits in entries 0..7, entry 8 Y=0 and entry 9 byte1=20 → no hit on entry 8; m advances to 1, so byte1 of entry 9 is read as Y → overflowSet (bug reproduced).
- spriteEvalReset asserted at d=100 mid-COPY, then a fresh line → evaluation restarts at CLEAR with found=0; spriteEval_EN dropped for 10 dots → state and oamAddr frozen, secWe=0.
